// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map constants, address classes and copier FSM states
package mem_map_pkg;

  // 64-word chip map: ROM is read-only, the two RAM windows are read/write
  localparam int ROM_LO  = 'h00;
  localparam int ROM_HI  = 'h0F;
  localparam int RAM1_LO = 'h10;
  localparam int RAM1_HI = 'h17;
  localparam int RAM2_LO = 'h28;
  localparam int RAM2_HI = 'h2F;

  // Largest block a single command may move (the whole map)
  localparam int MAX_LEN = 64;

  typedef enum logic [1:0] {
    UNMAPPED = 2'd0,
    ROM      = 2'd1,
    RAM      = 2'd2
  } addr_class_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    ADV   = 3'd3,
    DONE  = 3'd4
  } copier_state_t;

endpackage

// File: rtl/mem_map_decode.sv
// rtl/mem_map_decode.sv - combinational address-to-class decoder for the chip map
module mem_map_decode
  import mem_map_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output addr_class_t       addr_class
);

  // Signed view of the address so the low-bound compares are not trivially true
  int a;
  assign a = int'(addr);

  // Classify the address against the three mapped windows
  always_comb begin
    addr_class = UNMAPPED;
    if (a >= ROM_LO && a <= ROM_HI) begin
      addr_class = ROM;
    end else if ((a >= RAM1_LO && a <= RAM1_HI) || (a >= RAM2_LO && a <= RAM2_HI)) begin
      addr_class = RAM;
    end
  end

endmodule

// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - word-at-a-time block copy master for the 64-word memory chip
module mem_block_copier
  import mem_map_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  copier_state_t     state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  remaining;
  addr_class_t       src_class;
  addr_class_t       dst_class;

  // Both addresses of the current word are classified every cycle; only READ acts on it
  mem_map_decode #(.ADDR_W(ADDR_W)) u_src_decode (
    .addr       (src_q),
    .addr_class (src_class)
  );

  mem_map_decode #(.ADDR_W(ADDR_W)) u_dst_decode (
    .addr       (dst_q),
    .addr_class (dst_class)
  );

  // Copy FSM; all bus and status outputs are registered on the state transition.
  // mem_wdata doubles as the one-word buffer between READ and WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            remaining <= len;
            count     <= '0;
            mem_rw    <= 1'b0;
            if (len == '0 || len > LEN_W'(MAX_LEN)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= (len > LEN_W'(MAX_LEN));
            end else begin
              state    <= READ;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end
          end
        end

        READ: begin
          if (src_class == UNMAPPED || dst_class != RAM) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state     <= WRITE;
            mem_wdata <= mem_rdata;
            mem_addr  <= dst_q;
            mem_rw    <= 1'b1;
          end
        end

        // Drop RW while the address still points at dst so no neighbour gets written
        WRITE: begin
          state  <= ADV;
          mem_rw <= 1'b0;
        end

        ADV: begin
          count     <= count + 1'b1;
          src_q     <= src_q + 1'b1;
          dst_q     <= dst_q + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= READ;
            mem_addr <= src_q + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          mem_rw <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// tb/tb_mem_block_copier.sv - directed self-checking bench for mem_block_copier with a chip model
module tb_mem_block_copier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  src_addr = '0;
  logic [5:0]  dst_addr = '0;
  logic [6:0]  len = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  count;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rw;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_fail = 0;

  // Chip model state
  logic [15:0] mem [64];
  logic        clr_mem = 1'b1;
  int          bad_wr = 0;

  // Per-command observations
  int          done_cyc;
  logic        err_seen;
  logic [6:0]  cnt_seen;
  logic        busy_at_done;
  logic [63:0] rw_mask;

  always #5 clk = ~clk;

  mem_block_copier dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata)
  );

  function automatic logic readable(input logic [5:0] a);
    return (a <= 6'h0F) || (a >= 6'h10 && a <= 6'h17) || (a >= 6'h28 && a <= 6'h2F);
  endfunction

  function automatic logic writable(input logic [5:0] a);
    return (a >= 6'h10 && a <= 6'h17) || (a >= 6'h28 && a <= 6'h2F);
  endfunction

  // Combinational read path; unmapped addresses float
  always_comb begin
    mem_rdata = 16'hzzzz;
    if (readable(mem_addr)) mem_rdata = mem[mem_addr];
  end

  // Write path sampled mid-cycle; also reloads ROM and clears RAM on request
  always @(negedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i <= 15) ? (16'hFFFF - 16'(i)) : 16'h0000;
    end else if (mem_rw) begin
      if (writable(mem_addr)) mem[mem_addr] <= mem_wdata;
      else bad_wr <= bad_wr + 1;
    end
  end

  task automatic clear_mem();
    clr_mem = 1'b1;
    @(negedge clk);
    #1 clr_mem = 1'b0;
  endtask

  task automatic run_cmd(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len = l;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    err_seen = 1'b0;
    cnt_seen = '0;
    busy_at_done = 1'b1;
    rw_mask = '0;
    for (int c = 1; c <= 250 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_rw && c < 64) rw_mask[c] = 1'b1;
      if (done) begin
        done_cyc = c;
        err_seen = err;
        cnt_seen = count;
        busy_at_done = busy;
      end
    end
    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_timeout: got no done within 250 cycles, required a done pulse");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done, err});
    end
    n_checks++;
    if (count !== 7'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d required 0", count);
    end
    n_checks++;
    if ({mem_addr, mem_wdata, mem_rw} !== 23'd0) begin
      n_fail++; $display("FAIL reset_bus: got addr %h wdata %h rw %b required all zero", mem_addr, mem_wdata, mem_rw);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_copy();
    clear_mem();
    run_cmd(6'h00, 6'h10, 7'd4);
    n_checks++;
    if (done_cyc !== 13) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 13", done_cyc); end
    n_checks++;
    if (err_seen !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b required 0", err_seen); end
    n_checks++;
    if (cnt_seen !== 7'd4) begin n_fail++; $display("FAIL basic_count: got %0d required 4", cnt_seen); end
    n_checks++;
    if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done); end
    n_checks++;
    if (rw_mask !== 64'h924) begin n_fail++; $display("FAIL basic_rw_cycles: got %h required 924", rw_mask); end
    n_checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 64'hFFFF_FFFE_FFFD_FFFC) begin
      n_fail++; $display("FAIL basic_ram_data: got %h %h %h %h required FFFF FFFE FFFD FFFC", mem[16], mem[17], mem[18], mem[19]);
    end
    n_checks++;
    if (mem[20] !== 16'h0000) begin n_fail++; $display("FAIL basic_no_overrun: got %h required 0000", mem[20]); end
  endtask

  task automatic test_len_bounds();
    run_cmd(6'h00, 6'h10, 7'd0);
    n_checks++;
    if (done_cyc !== 1 || err_seen !== 1'b0) begin
      n_fail++; $display("FAIL len0_done: got cycle %0d err %b required cycle 1 err 0", done_cyc, err_seen);
    end
    n_checks++;
    if (rw_mask !== 64'h0) begin n_fail++; $display("FAIL len0_rw: got %h required 0", rw_mask); end
    run_cmd(6'h00, 6'h10, 7'd65);
    n_checks++;
    if (done_cyc !== 1 || err_seen !== 1'b1) begin
      n_fail++; $display("FAIL len65_done: got cycle %0d err %b required cycle 1 err 1", done_cyc, err_seen);
    end
  endtask

  task automatic test_rom_dest();
    clear_mem();
    run_cmd(6'h02, 6'h05, 7'd2);
    n_checks++;
    if (done_cyc !== 2 || err_seen !== 1'b1 || cnt_seen !== 7'd0) begin
      n_fail++; $display("FAIL romdst_abort: got cycle %0d err %b count %0d required cycle 2 err 1 count 0", done_cyc, err_seen, cnt_seen);
    end
    n_checks++;
    if (rw_mask !== 64'h0) begin n_fail++; $display("FAIL romdst_rw: got %h required 0", rw_mask); end
    n_checks++;
    if (mem[5] !== 16'hFFFA || mem[6] !== 16'hFFF9) begin
      n_fail++; $display("FAIL romdst_rom: got %h %h required FFFA FFF9", mem[5], mem[6]);
    end
  endtask

  task automatic test_ram_boundary();
    clear_mem();
    run_cmd(6'h00, 6'h16, 7'd4);
    n_checks++;
    if (mem[22] !== 16'hFFFF || mem[23] !== 16'hFFFE) begin
      n_fail++; $display("FAIL edge_data: got %h %h required FFFF FFFE", mem[22], mem[23]);
    end
    n_checks++;
    if (done_cyc !== 8 || err_seen !== 1'b1 || cnt_seen !== 7'd2) begin
      n_fail++; $display("FAIL edge_abort: got cycle %0d err %b count %0d required cycle 8 err 1 count 2", done_cyc, err_seen, cnt_seen);
    end
    n_checks++;
    if (rw_mask !== 64'h24) begin n_fail++; $display("FAIL edge_rw: got %h required 24", rw_mask); end
    n_checks++;
    if (bad_wr !== 0) begin n_fail++; $display("FAIL edge_bad_writes: got %0d required 0", bad_wr); end
  endtask

  task automatic test_unmapped_and_ram2();
    clear_mem();
    run_cmd(6'h3F, 6'h28, 7'd1);
    n_checks++;
    if (done_cyc !== 2 || err_seen !== 1'b1 || cnt_seen !== 7'd0) begin
      n_fail++; $display("FAIL unmapped_src: got cycle %0d err %b count %0d required cycle 2 err 1 count 0", done_cyc, err_seen, cnt_seen);
    end
    n_checks++;
    if (mem[40] !== 16'h0000) begin n_fail++; $display("FAIL unmapped_dst_untouched: got %h required 0000", mem[40]); end
    run_cmd(6'h0E, 6'h2E, 7'd2);
    n_checks++;
    if (done_cyc !== 7 || err_seen !== 1'b0 || cnt_seen !== 7'd2) begin
      n_fail++; $display("FAIL ram2_status: got cycle %0d err %b count %0d required cycle 7 err 0 count 2", done_cyc, err_seen, cnt_seen);
    end
    n_checks++;
    if (mem[46] !== 16'hFFF1 || mem[47] !== 16'hFFF0) begin
      n_fail++; $display("FAIL ram2_data: got %h %h required FFF1 FFF0", mem[46], mem[47]);
    end
  endtask

  task automatic test_reset_midcopy();
    int ndone;
    clear_mem();
    @(negedge clk);
    src_addr = 6'h00; dst_addr = 6'h10; len = 7'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    n_checks++;
    if (mem_rw !== 1'b1 || mem_addr !== 6'h12) begin
      n_fail++; $display("FAIL midrst_in_write: got rw %b addr %h required 1 12", mem_rw, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err, mem_rw} !== 4'b0000 || count !== 7'd0 || mem_addr !== 6'h00 || mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy %b done %b err %b rw %b count %0d addr %h wdata %h required all zero",
                         busy, done, err, mem_rw, count, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    clear_mem();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    done_cyc = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) begin ndone++; done_cyc = c; end
      start = (c == 3 || c == 12 || c == 13);
    end
    start = 1'b0;
    n_checks++;
    if (ndone !== 1 || done_cyc !== 13) begin
      n_fail++; $display("FAIL rerun_done: got %0d pulses last cycle %0d required 1 pulse at cycle 13", ndone, done_cyc);
    end
    n_checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 64'hFFFF_FFFE_FFFD_FFFC) begin
      n_fail++; $display("FAIL rerun_data: got %h %h %h %h required FFFF FFFE FFFD FFFC", mem[16], mem[17], mem[18], mem[19]);
    end
  endtask

  initial begin
    @(negedge clk);
    #1 clr_mem = 1'b0;
    test_reset();
    test_basic_copy();
    test_len_bounds();
    test_rom_dest();
    test_ram_boundary();
    test_unmapped_and_ram2();
    test_reset_midcopy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_copier.md
# mem_block_copier

Bus-master stage that sits directly upstream of the 64-word memory chip (ROM 0x00–0x0F, RAM 0x10–0x17 and 0x28–0x2F) and drives its address, write-data and read/write lines. On a start command it copies a block of words from a source address to a destination address one word at a time, reading through the chip's combinational read path and writing through its level-sensitive write path. Per-word address checks against the memory map abort the copy on any unmapped source or non-writable destination.

## Interface
- ADDR_W, 6, memory address width (64-word map)
- DATA_W, 16, memory word width
- LEN_W, 7, length field width (0..64 words)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  copy request, sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- len  in  LEN_W  number of words, 0..64
- busy  out  1  high while a copy is in progress
- done  out  1  one-cycle pulse at end of every accepted command
- err  out  1  one-cycle pulse with done when the command aborted
- count  out  LEN_W  words written by the last/current command
- mem_addr  out  ADDR_W  to chip addr
- mem_wdata  out  DATA_W  to chip data in
- mem_rw  out  1  to chip RW (1 = write, 0 = read)
- mem_rdata  in  DATA_W  from chip data out

## Operation
- All outputs are registered. Reset values: busy 0, done 0, err 0, count 0, mem_addr 0, mem_wdata 0, mem_rw 0. The state is IDLE.
- States:
  - IDLE: on start, latch src, dst and len, clear count, and set busy. Go to DONE if len==0 or len>64 (err=1 when len>64). Otherwise go to READ.
  - READ: mem_rw=0, mem_addr=src. Check the address class. If src is unmapped or dst is not RAM, go to DONE with err=1. Otherwise capture mem_rdata into the word buffer at the clock edge and go to WRITE.
  - WRITE: mem_addr=dst, mem_wdata=buffer, mem_rw=1 for exactly one cycle. Go to ADV.
  - ADV: mem_rw=0, and mem_addr stays at dst. This drops RW before the address moves, so the level-sensitive RAM never writes a neighbouring word. Increment count, src and dst, and decrement the remaining count. Go to DONE if remaining reaches 0, else READ.
  - DONE: busy=0, done=1, err as decided. Return to IDLE next cycle.
- Addresses increment modulo 64 (0x3F wraps to 0x00). Each word is re-checked after the wrap.
- Words already written before an abort stay written. count reports them.
- start is ignored while not in IDLE, including during the DONE cycle.
- rst mid-copy returns to IDLE at the next edge with mem_rw=0. A write in progress may complete.
- Source classes: ROM (0x00–0x0F), RAM1 (0x10–0x17) and RAM2 (0x28–0x2F) are readable. Only RAM1 and RAM2 are writable. Everything else is unmapped.

## Timing
- Edge 0 samples start. busy is high from cycle 1.
- Each word takes 3 cycles (READ, WRITE, ADV). For len=N with no error, done pulses in cycle 3N+1 and busy is low in that cycle.
- len=0 or len>64: done pulses in cycle 1.
- Abort on word k (0-based): done/err pulse in cycle 3k+2, with count=k.
- mem_rdata must be stable within the READ cycle, since the chip's read path is combinational.

## Structure
- Package mem_map_pkg holds:
  - the map constants ROM_LO/HI (0x00/0x0F), RAM1_LO/HI (0x10/0x17) and RAM2_LO/HI (0x28/0x2F);
  - the address-class typedef (UNMAPPED, ROM, RAM);
  - the FSM state typedef (IDLE, READ, WRITE, ADV, DONE).
- One sub-module, mem_map_decode: combinational, address in, class out. It is instantiated twice (src and dst).

## Test plan
All scenarios use the memory chip model as the bench memory. ROM word i holds ~i.

- src=0x00, dst=0x10, len=4 -> RAM 0x10..0x13 hold FFFF, FFFE, FFFD, FFFC. done in cycle 13, err=0, count=4. mem_rw is high only in cycles 2, 5, 8 and 11.
- len=0 -> done in cycle 1 and mem_rw never rises. len=65 -> done+err in cycle 1.
- src=0x02, dst=0x05 (ROM), len=2 -> err in cycle 2, count=0, mem_rw never high, ROM unchanged.
- src=0x00, dst=0x16, len=4 -> 0x16=FFFF and 0x17=FFFE. The word to 0x18 aborts with err in cycle 8, count=2, and the chip's z is never written anywhere.
- src=0x3F (unmapped), dst=0x28, len=1 -> err. Separately, src=0x0E, dst=0x2E, len=2 -> 0x2E=FFF1, 0x2F=FFF0.
- Assert rst during WRITE of word 2, then assert start during busy -> after rst the outputs are at reset values. Pulses of start while busy produce no extra done. Re-running the copy from scratch succeeds.
